// File: rtl/ebus_arbiter.sv
// KL10 EBUS arbiter: round-robin ownership of the bus among master-side requesters
// and timing of the demand / transfer-acknowledge handshake for the current owner.
module ebus_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned SETUP   = 2,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic [NREQ-1:0] ebusReq,
  input  logic [NREQ-1:0] ebusDemandReq,
  input  logic [NREQ-1:0] ebusReturn,
  input  logic            ebusXfer,
  output logic [NREQ-1:0] ebusGrant,
  output logic            ebusDemand,
  output logic [NREQ-1:0] xferDone,
  output logic [NREQ-1:0] xferTimeout,
  output logic            ebusBusy
);

  localparam int unsigned OW = $clog2(NREQ);

  typedef enum logic [2:0] {StIdle, StGrant, StSetup, StDemand, StHold} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [3:0]      setup_cnt_q, setup_cnt_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] tmo_q, tmo_d;
  logic            demand_q, demand_d;
  logic            busy_q, busy_d;

  logic [OW-1:0]   winner, idx;
  logic            win_valid;
  logic            own_req, own_dreq, own_ret;
  logic            setup_hit, wait_hit, rel;

  assign own_req   = ebusReq[owner_q];
  assign own_dreq  = ebusDemandReq[owner_q];
  assign own_ret   = ebusReturn[owner_q];
  assign setup_hit = setup_cnt_q >= 4'(SETUP - 1);
  assign wait_hit  = wait_cnt_q >= 8'(TIMEOUT - 1);

  // Search upward from the requester after the last releaser, wrapping modulo NREQ.
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = OW'((32'(ptr_q) + k) % NREQ);
      if (!win_valid && ebusReq[idx]) begin
        winner    = idx;
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    setup_cnt_d = setup_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    grant_d     = grant_q;
    demand_d    = 1'b0;
    done_d      = '0;
    tmo_d       = '0;
    rel         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          owner_d         = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          state_d         = StGrant;
        end
      end
      StGrant: begin
        if (!own_req) begin
          rel = 1'b1;
        end else if (own_dreq) begin
          state_d     = StSetup;
          setup_cnt_d = '0;
        end
      end
      StSetup: begin
        if (!own_req) begin
          rel = 1'b1;
        end else if (setup_hit && !ebusXfer) begin
          state_d    = StDemand;
          demand_d   = 1'b1;
          wait_cnt_d = '0;
        end else if (setup_cnt_q != 4'hF) begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end
      StDemand: begin
        // Acknowledge is checked before the timeout so a coincident ack wins.
        if (!own_req) begin
          rel = 1'b1;
        end else if (ebusXfer) begin
          done_d[owner_q] = 1'b1;
          state_d         = StHold;
        end else if (wait_hit) begin
          tmo_d[owner_q] = 1'b1;
          state_d        = StHold;
        end else begin
          demand_d = 1'b1;
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (own_ret || !own_req) begin
          rel = 1'b1;
        end else if (own_dreq) begin
          state_d     = StSetup;
          setup_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rel) begin
      state_d = StIdle;
      grant_d = '0;
      ptr_d   = owner_q;
    end
  end

  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      ptr_q       <= OW'(NREQ - 1);
      setup_cnt_q <= '0;
      wait_cnt_q  <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      tmo_q       <= '0;
      demand_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      setup_cnt_q <= setup_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      demand_q    <= demand_d;
      busy_q      <= busy_d;
    end
  end

  assign ebusGrant   = grant_q;
  assign ebusDemand  = demand_q;
  assign xferDone    = done_q;
  assign xferTimeout = tmo_q;
  assign ebusBusy    = busy_q;

endmodule

// File: tb/tb_ebus_arbiter.sv
// Bench for ebus_arbiter: vector table, directed handshake sequences, and a
// randomized run checked cycle by cycle against a behavioural model.
module tb_ebus_arbiter;

  localparam int N       = 4;
  localparam int SETUP   = 2;
  localparam int TIMEOUT = 63;

  logic         clk = 1'b0;
  logic         resetN = 1'b1;
  logic [N-1:0] ebusReq = '0, ebusDemandReq = '0, ebusReturn = '0;
  logic         ebusXfer = 1'b0;
  logic [N-1:0] ebusGrant, xferDone, xferTimeout;
  logic         ebusDemand, ebusBusy;

  int n_checks = 0;
  int n_fail   = 0;

  ebus_arbiter #(.NREQ(N), .SETUP(SETUP), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .ebusReq      (ebusReq),
    .ebusDemandReq(ebusDemandReq),
    .ebusReturn   (ebusReturn),
    .ebusXfer     (ebusXfer),
    .ebusGrant    (ebusGrant),
    .ebusDemand   (ebusDemand),
    .xferDone     (xferDone),
    .xferTimeout  (xferTimeout),
    .ebusBusy     (ebusBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req, dreq, ret;
    logic       xfer;
    logic [3:0] grant;
    logic       demand;
    logic [3:0] done, tmo;
    logic       busy;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string name, input logic [3:0] eg, input logic ed,
                          input logic [3:0] edn, input logic [3:0] et, input logic eb);
    chk(name, 32'({ebusGrant, ebusDemand, xferDone, xferTimeout, ebusBusy}),
        32'({eg, ed, edn, et, eb}));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ebusReq = '0; ebusDemandReq = '0; ebusReturn = '0; ebusXfer = 1'b0;
  endtask

  task automatic reset_dut();
    tick();
    resetN = 1'b0;
    clear_inputs();
    tick();
    tick();
    chk_outs("reset_state", 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    resetN = 1'b1;
  endtask

  // Pulse the owner's demand request, then count cycles until DEMAND appears.
  task automatic wait_demand(input logic [3:0] dmask, output int n);
    ebusDemandReq = dmask;
    tick();
    ebusDemandReq = '0;
    n = 1;
    while (!ebusDemand && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Count DEMAND-high cycles; raise ack during the ack_at-th one (0 = never).
  task automatic count_demand(input int ack_at, output int d);
    int g;
    d = 0;
    g = 0;
    while (ebusDemand && g < 300) begin
      d++;
      if (d == ack_at) ebusXfer = 1'b1;
      tick();
      g++;
    end
  endtask

  // Behavioural model: owner index (-1 = free) plus phase flags and elapsed counts.
  int         m_owner, m_ptr, m_sel, m_del;
  bit         m_in_setup, m_in_dem, m_after;
  logic [3:0] m_done, m_tmo;

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_sel = 0; m_del = 0;
    m_in_setup = 0; m_in_dem = 0; m_after = 0;
    m_done = '0; m_tmo = '0;
  endtask

  task automatic model_release();
    m_ptr = m_owner; m_owner = -1;
    m_in_setup = 0; m_in_dem = 0; m_after = 0;
  endtask

  task automatic model_step();
    m_done = '0;
    m_tmo  = '0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && ebusReq[c]) m_owner = c;
      end
    end else if (!ebusReq[m_owner]) begin
      model_release();
    end else if (m_in_dem) begin
      if (ebusXfer) begin
        m_done[m_owner] = 1'b1; m_in_dem = 0; m_after = 1;
      end else if (m_del + 1 >= TIMEOUT) begin
        m_tmo[m_owner] = 1'b1; m_in_dem = 0; m_after = 1;
      end else begin
        m_del++;
      end
    end else if (m_in_setup) begin
      m_sel++;
      if (m_sel >= SETUP && !ebusXfer) begin
        m_in_setup = 0; m_in_dem = 1; m_del = 0;
      end
    end else if (m_after && ebusReturn[m_owner]) begin
      model_release();
    end else if (ebusDemandReq[m_owner]) begin
      m_in_setup = 1; m_sel = 0;
    end
  endtask

  bit mon_en = 0;
  int mon_done = 0, mon_bad = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (ebusGrant !== 4'b0001) mon_bad++;
      if (xferDone === 4'b0001) mon_done++;
    end
  end

  initial begin
    int n, d, seen;
    logic [3:0] eg;

    //          req      dreq     ret      x     grant    dem   done     tmo      busy
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[1]  = '{4'b1110, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[3]  = '{4'b1101, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[5]  = '{4'b1011, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[7]  = '{4'b0111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[9]  = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[10] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[12] = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1};
    tbl[13] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};

    reset_dut();
    for (int i = 0; i < 15; i++) begin
      ebusReq = tbl[i].req; ebusDemandReq = tbl[i].dreq;
      ebusReturn = tbl[i].ret; ebusXfer = tbl[i].xfer;
      tick();
      chk_outs($sformatf("vec%0d", i), tbl[i].grant, tbl[i].demand, tbl[i].done,
               tbl[i].tmo, tbl[i].busy);
    end
    clear_inputs();

    // Owner 1: acknowledge in the 5th DEMAND cycle, grant held until return.
    ebusReq = 4'b0010;
    tick();
    chk_outs("a_grant", 4'b0010, 1'b0, 4'b0, 4'b0, 1'b1);
    wait_demand(4'b0010, n);
    chk("a_setup_delay", 32'(n), 32'(SETUP + 1));
    count_demand(5, d);
    chk("a_demand_len", 32'(d), 32'd5);
    chk_outs("a_done", 4'b0010, 1'b0, 4'b0010, 4'b0, 1'b1);
    ebusXfer = 1'b0;
    tick();
    chk_outs("a_hold", 4'b0010, 1'b0, 4'b0, 4'b0, 1'b1);
    tick();
    chk_outs("a_hold2", 4'b0010, 1'b0, 4'b0, 4'b0, 1'b1);
    ebusReturn = 4'b0010;
    tick();
    chk_outs("a_release", 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    clear_inputs();

    // Owner 2: no acknowledge, so the transfer times out.
    ebusReq = 4'b0100;
    tick();
    chk_outs("b_grant", 4'b0100, 1'b0, 4'b0, 4'b0, 1'b1);
    wait_demand(4'b0100, n);
    count_demand(0, d);
    chk("b_demand_len", 32'(d), 32'(TIMEOUT));
    chk_outs("b_timeout", 4'b0100, 1'b0, 4'b0, 4'b0100, 1'b1);
    tick();
    chk_outs("b_hold", 4'b0100, 1'b0, 4'b0, 4'b0, 1'b1);
    ebusReturn = 4'b0100;
    tick();
    chk_outs("b_release", 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    clear_inputs();

    // Owner 3: stale acknowledge during SETUP withholds DEMAND.
    ebusReq = 4'b1000;
    tick();
    chk_outs("c_grant", 4'b1000, 1'b0, 4'b0, 4'b0, 1'b1);
    ebusXfer = 1'b1;
    ebusDemandReq = 4'b1000;
    tick();
    ebusDemandReq = '0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ebusDemand) seen = 1;
    end
    chk("c_withheld", 32'(seen), 32'd0);
    ebusXfer = 1'b0;
    tick();
    chk_outs("c_demand", 4'b1000, 1'b1, 4'b0, 4'b0, 1'b1);
    ebusXfer = 1'b1;
    tick();
    chk_outs("c_done", 4'b1000, 1'b0, 4'b1000, 4'b0, 1'b1);
    ebusXfer = 1'b0;
    ebusReturn = 4'b1000;
    tick();
    chk_outs("c_release", 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    clear_inputs();

    // Owner 0: two back-to-back transfers from HOLD while everyone else requests.
    ebusReq = 4'b1111;
    tick();
    chk_outs("d_grant", 4'b0001, 1'b0, 4'b0, 4'b0, 1'b1);
    mon_done = 0;
    mon_bad = 0;
    mon_en = 1;
    for (int t = 0; t < 2; t++) begin
      wait_demand(4'b0001, n);
      count_demand(2, d);
      ebusXfer = 1'b0;
    end
    tick();
    mon_en = 0;
    chk("d_dones", 32'(mon_done), 32'd2);
    chk("d_grant_cont", 32'(mon_bad), 32'd0);
    ebusReturn = 4'b0001;
    ebusReq = '0;
    tick();
    chk_outs("d_release", 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    clear_inputs();

    // Owner 1 mid-DEMAND: asynchronous reset clears everything between edges.
    ebusReq = 4'b0010;
    tick();
    ebusReq = 4'b1111;
    wait_demand(4'b0010, n);
    chk_outs("e_pre_reset", 4'b0010, 1'b1, 4'b0, 4'b0, 1'b1);
    #2 resetN = 1'b0;
    #1 chk_outs("e_async_reset", 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    resetN = 1'b1;
    tick();
    chk_outs("e_after_reset", 4'b0001, 1'b0, 4'b0, 4'b0, 1'b1);
    clear_inputs();

    // Randomized run against the model.
    reset_dut();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit quiet;
      quiet = (c % 400) < 120;
      for (int b = 0; b < N; b++) begin
        if (!quiet && $urandom_range(9) == 0) ebusReq[b] = ~ebusReq[b];
        ebusDemandReq[b] = ($urandom_range(2) == 0);
        ebusReturn[b]    = ($urandom_range(7) == 0);
      end
      ebusXfer = quiet ? 1'b0 : ($urandom_range(3) == 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      chk_outs($sformatf("rand_c%0d", c), eg, m_in_dem, m_done, m_tmo, m_owner >= 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ebus_arbiter.md
Name: ebus_arbiter

Overview:
- Arbitrates and sequences the KL10 EBUS between up to NREQ master-side requesters (APR, PI, MTR, console interface, ...).
- Grants one requester at a time using round-robin priority.
- Times the EBUS demand/transfer handshake for the owner: setup delay, demand assertion, transfer acknowledge or timeout, then bus return.
- Carries no data; owners drive function, DS and data lines only while their grant is asserted.

Parameters:
NREQ, 4, number of requesters (2..8)
SETUP, 2, cycles between the owner's demand request and assertion of EBUS DEMAND (1..15)
TIMEOUT, 63, cycles DEMAND may wait for a transfer acknowledge before timing out (1..255)

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous active-low reset
ebusReq  input  NREQ  per-requester bus request; bit 0 is requester 0
ebusDemandReq  input  NREQ  owner asks to start the demand phase
ebusReturn  input  NREQ  owner releases the bus
ebusXfer  input  1  wired-OR transfer acknowledge from the addressed device
ebusGrant  output  NREQ  one-hot grant; all zero when the bus is free
ebusDemand  output  1  EBUS DEMAND line
xferDone  output  NREQ  one-cycle pulse to the owner on acknowledge
xferTimeout  output  NREQ  one-cycle pulse to the owner on timeout
ebusBusy  output  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; round-robin pointer = NREQ-1, so requester 0 wins first; counters 0. Reset is asynchronous in every state, including mid-demand. Demand and grant drop immediately; no done or timeout pulse is emitted.
- States: IDLE, GRANT, SETUP, DEMAND, HOLD. All outputs are registered.
- IDLE:
  - If any ebusReq bit is set, pick the first set bit searching upward from pointer+1, with modulo-NREQ wrap.
  - Record the winner as owner; ebusGrant[owner]=1 on the next cycle; go to GRANT.
  - Latency from request to grant is 1 cycle.
- GRANT:
  - ebusDemandReq[owner]=1 -> SETUP, counter cleared.
  - ebusReq[owner]=0 -> IDLE, grant cleared, pointer=owner.
  - Demand request bits from non-owners are ignored in every state.
- SETUP:
  - Count SETUP cycles.
  - When the count is reached and ebusXfer=0, go to DEMAND and set ebusDemand=1.
  - If ebusXfer=1 when the count is reached (stale acknowledge), stay in SETUP until it drops.
- DEMAND:
  - ebusDemand is held at 1.
  - ebusXfer=1 -> xferDone[owner] pulses, ebusDemand=0, go to HOLD.
  - Otherwise, when the wait counter reaches TIMEOUT cycles -> xferTimeout[owner] pulses, ebusDemand=0, go to HOLD.
  - If ebusXfer rises in the same cycle the timeout expires, acknowledge wins: xferDone only.
  - ebusDemand is asserted for exactly N cycles, where N = acknowledge latency, with 1 <= N <= TIMEOUT.
- HOLD:
  - The owner keeps the grant, so it can sample data or issue another demand.
  - ebusDemandReq[owner]=1 with ebusReturn[owner]=0 -> SETUP, for a back-to-back transfer without rearbitration.
  - ebusReturn[owner]=1 or ebusReq[owner]=0 -> IDLE: grant drops the next cycle, pointer=owner.
  - Return has priority over a simultaneous demand request.
- Fairness:
  - The pointer updates only on release.
  - A requester that continuously holds its request waits at most NREQ-1 tenures.
- Owner dropping ebusReq in SETUP or DEMAND:
  - Demand drops and the state goes to IDLE with no pulse.
  - The pointer is still updated.
- Widths:
  - Setup counter is 4 bits; timeout counter is 8 bits.
  - Owner index is ceil(log2 NREQ) bits.
  - Counters saturate and never wrap.

Test Plan:
- Reset with all ebusReq=1 -> ebusGrant=0001b one cycle after resetN rises. Release owner 0, keep the others requesting -> grants 0010b, 0100b, 1000b, then 0001b in turn.
- Owner 1 granted, ebusDemandReq[1]=1, SETUP=2, ebusXfer rises 5 cycles after DEMAND asserts -> ebusDemand high exactly 5 cycles; xferDone=0010b for 1 cycle; grant held until ebusReturn[1].
- ebusXfer held 0 with TIMEOUT=63 -> ebusDemand high 63 cycles; xferTimeout[owner] 1-cycle pulse; state HOLD; no xferDone.
- ebusXfer=1 already during SETUP -> DEMAND withheld until ebusXfer=0, then asserted the next cycle.
- Two back-to-back demands in HOLD without return -> two xferDone pulses; grant continuous; no other requester is granted in between.
- resetN pulsed low during DEMAND -> ebusDemand, ebusGrant and ebusBusy are 0 immediately (asynchronously); no pulses; after release, requester 0 has priority.
